// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: port ids, default sizes, response tag.
// Optional DMEM_ARB_STATS_EN build adds conflict/force counters to the top.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF     = 11;
  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W_DEF      = 3;

  localparam logic PORT_PIPE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } resp_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and dmem bundle for dmem_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 11
) ();

  logic              p0_req;
  logic              p0_we;
  logic              p0_kill;
  logic [31:0]       p0_addr;
  logic [31:0]       p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [31:0]       p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [31:0]       p1_addr;
  logic [31:0]       p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [31:0]       p1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_kill,
    input  p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we,
    input  p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we,
    output mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_kill,
    output p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we,
    output p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating counter of consecutive denied aux-port request cycles.
// full flags that the aux port must win the next conflict.
module dmem_arb_starve_ctr #(
  parameter int CNT_W = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign full = (cnt_q == CNT_W'(MAX));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !full) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: pipeline port has priority, aux port has a
// starvation guard. DMEM_ARB_STATS_EN adds stat_conflict/stat_force.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]    stat_conflict,
  output logic [31:0]    stat_force
`endif
);

  logic             p0_win;
  logic             p1_win;
  logic             any_win;
  logic             kill_wr;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             starve_full;
  logic             starve_clr;
  logic [CNT_W-1:0] starve_cnt;
  logic             unused_ok;
  resp_tag_t        resp_q;
  resp_tag_t        resp_d;

  dmem_arb_starve_ctr #(
    .CNT_W (CNT_W),
    .MAX   (STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .rst  (rst),
    .clr  (starve_clr),
    .inc  (~starve_clr),
    .cnt  (starve_cnt),
    .full (starve_full)
  );

  always_comb begin
    p1_win     = bus.p1_req & (~bus.p0_req | starve_full);
    p0_win     = bus.p0_req & ~p1_win;
    any_win    = p0_win | p1_win;
    starve_clr = ~bus.p1_req | p1_win;
    sel_we     = p1_win ? bus.p1_we    : bus.p0_we;
    sel_addr   = p1_win ? bus.p1_addr  : bus.p0_addr;
    sel_wdata  = p1_win ? bus.p1_wdata : bus.p0_wdata;
    // a killed store still takes its slot so the pipeline can advance
    kill_wr    = p0_win & bus.p0_we & bus.p0_kill;
  end

  assign bus.p0_gnt    = p0_win;
  assign bus.p1_gnt    = p1_win;
  assign bus.mem_en    = any_win & ~kill_wr;
  assign bus.mem_we    = any_win & ~kill_wr & sel_we;
  assign bus.mem_addr  = sel_addr[ADDR_W+1:2];
  assign bus.mem_wdata = sel_wdata;

  assign unused_ok = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0], starve_cnt};

  always_comb begin
    resp_d       = '0;
    resp_d.valid = any_win & ~sel_we;
    resp_d.port  = p1_win ? PORT_AUX : PORT_PIPE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  assign bus.p0_rvalid = resp_q.valid & (resp_q.port == PORT_PIPE);
  assign bus.p1_rvalid = resp_q.valid & (resp_q.port == PORT_AUX);
  assign bus.p0_rdata  = bus.mem_rdata;
  assign bus.p1_rdata  = bus.mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] conflict_q;
  logic [31:0] conflict_d;
  logic [31:0] force_q;
  logic [31:0] force_d;

  always_comb begin
    conflict_d = conflict_q;
    force_d    = force_q;
    if (bus.p0_req && bus.p1_req) begin
      conflict_d = conflict_q + 32'd1;
    end
    if (bus.p0_req && p1_win) begin
      force_d = force_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
      force_q    <= '0;
    end else begin
      conflict_q <= conflict_d;
      force_q    <= force_d;
    end
  end

  assign stat_conflict = conflict_q;
  assign stat_force    = force_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses, queued read
// expectations checked by an independent response monitor.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  dmem_arbiter_if #(.ADDR_W(11)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_conflict;
  logic [31:0] stat_force;
`endif

  dmem_arbiter #(
    .ADDR_W     (11),
    .STARVE_MAX (4),
    .CNT_W      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_conflict (stat_conflict),
    .stat_force    (stat_force)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write-first synchronous dmem model
  logic [31:0] mem [0:2047];
  logic [31:0] rdata_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        rdata_q <= bus.mem_wdata;
      end else begin
        rdata_q <= mem[bus.mem_addr];
      end
    end
  end

  assign bus.mem_rdata = rdata_q;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.p0_rvalid || bus.p1_rvalid) begin
      total++;
      if (bus.p0_rvalid && bus.p1_rvalid) begin
        bad++;
        $display("FAIL rvalid_both: got p0=1 p1=1 want one");
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rvalid_unexp: got p0=%0b p1=%0b want none",
                 bus.p0_rvalid, bus.p1_rvalid);
      end else begin
        e = exp_q.pop_front();
        if (bus.p1_rvalid !== e.port) begin
          bad++;
          $display("FAIL resp_port: got %0b want %0b",
                   bus.p1_rvalid, e.port);
        end else if ((e.port ? bus.p1_rdata : bus.p0_rdata) !== e.data) begin
          bad++;
          $display("FAIL resp_data: got %h want %h",
                   e.port ? bus.p1_rdata : bus.p0_rdata, e.data);
        end
      end
    end
  end

  task automatic drive(input logic r0, w0, k0,
                       input logic [31:0] a0, d0,
                       input logic r1, w1,
                       input logic [31:0] a1, d1);
    bus.p0_req   = r0;
    bus.p0_we    = w0;
    bus.p0_kill  = k0;
    bus.p0_addr  = a0;
    bus.p0_wdata = d0;
    bus.p1_req   = r1;
    bus.p1_we    = w1;
    bus.p1_addr  = a1;
    bus.p1_wdata = d1;
  endtask

  task automatic step(input string nm,
                      input logic r0, w0, k0,
                      input logic [31:0] a0, d0,
                      input logic r1, w1,
                      input logic [31:0] a1, d1,
                      input logic eg0, eg1, een, ewe,
                      input logic [10:0] eaddr,
                      input logic [31:0] edata);
    exp_t e;
    drive(r0, w0, k0, a0, d0, r1, w1, a1, d1);
    @(negedge clk);
    chk({nm, ".p0_gnt"}, 32'(bus.p0_gnt), 32'(eg0));
    chk({nm, ".p1_gnt"}, 32'(bus.p1_gnt), 32'(eg1));
    chk({nm, ".mem_en"}, 32'(bus.mem_en), 32'(een));
    chk({nm, ".mem_we"}, 32'(bus.mem_we), 32'(ewe));
    if (een) chk({nm, ".mem_addr"}, 32'(bus.mem_addr), 32'(eaddr));
    if (!rst && ((eg0 && !w0) || (eg1 && !w1))) begin
      e.port = eg1;
      e.data = edata;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'h0, 0);
  endtask

  task automatic p1_wr(input logic [31:0] a, d);
    step("preload", 0, 0, 0, 0, 0, 1, 1, a, d,
         0, 1, 1, 1, a[12:2], 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.p0_rvalid", 32'(bus.p0_rvalid), 0);
    chk("rst.p1_rvalid", 32'(bus.p1_rvalid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    p1_wr(32'h40, 32'hDEADBEEF);
    p1_wr(32'h04, 32'h11111111);
    p1_wr(32'h08, 32'h22222222);
    p1_wr(32'h0C, 32'h33333333);
    p1_wr(32'h80, 32'hCAFEF00D);

    step("p0_rd40", 1, 0, 0, 32'h40, 0, 0, 0, 0, 0,
         1, 0, 1, 0, 11'h010, 32'hDEADBEEF);
    step("p0_kill_st", 1, 1, 1, 32'h80, 32'h12345678, 0, 0, 0, 0,
         1, 0, 0, 0, 11'h020, 0);
    step("p1_rd80", 0, 0, 0, 0, 0, 1, 0, 32'h80, 0,
         0, 1, 1, 0, 11'h020, 32'hCAFEF00D);

    step("alt_p0_4", 1, 0, 0, 32'h04, 0, 0, 0, 0, 0,
         1, 0, 1, 0, 11'h001, 32'h11111111);
    step("alt_p1_8", 0, 0, 0, 0, 0, 1, 0, 32'h08, 0,
         0, 1, 1, 0, 11'h002, 32'h22222222);
    step("alt_p0_c", 1, 0, 0, 32'h0C, 0, 0, 0, 0, 0,
         1, 0, 1, 0, 11'h003, 32'h33333333);

    step("wr100", 0, 0, 0, 0, 0, 1, 1, 32'h100, 32'hAAAA5555,
         0, 1, 1, 1, 11'h040, 0);
    step("rd100", 1, 0, 0, 32'h100, 0, 0, 0, 0, 0,
         1, 0, 1, 0, 11'h040, 32'hAAAA5555);
    step("kill_ld", 1, 0, 1, 32'h40, 0, 0, 0, 0, 0,
         1, 0, 1, 0, 11'h010, 32'hDEADBEEF);

    // build up starvation, then reset must clear it
    for (int i = 0; i < 2; i++) begin
      step("pre_conf", 1, 1, 0, 32'h200, 32'h5, 1, 1, 32'h300, 32'h6,
           1, 0, 1, 1, 11'h080, 0);
    end
    rst = 1'b1;
    step("rst_rd", 1, 0, 0, 32'h04, 0, 0, 0, 0, 0,
         1, 0, 1, 0, 11'h001, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_drop.p0_rvalid", 32'(bus.p0_rvalid), 0);
    chk("rst_drop.p1_rvalid", 32'(bus.p1_rvalid), 0);
    @(posedge clk);
    #1;
    step("post_rst_p1", 0, 0, 0, 0, 0, 1, 0, 32'h08, 0,
         0, 1, 1, 0, 11'h002, 32'h22222222);

    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) begin
        step("starve_p1", 1, 1, 0, 32'h200, 32'h5, 1, 1, 32'h300, 32'h6,
             0, 1, 1, 1, 11'h0C0, 0);
      end else begin
        step("starve_p0", 1, 1, 0, 32'h200, 32'h5, 1, 1, 32'h300, 32'h6,
             1, 0, 1, 1, 11'h080, 0);
      end
    end
    idle("idle0");
`ifdef DMEM_ARB_STATS_EN
    chk("stat_conflict", stat_conflict, 32'd10);
    chk("stat_force", stat_force, 32'd2);
`endif
    idle("idle1");
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
